// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the nibble-serial add/sub/compare sequencer:
//   - op_e     : operation codes (OP_ADD, OP_SUB, OP_CMP)
//   - state_e  : controller state encoding (S_IDLE, S_RUN, S_DONE)
//   - NIBBLE   : slice width processed per cycle
//   - decode_op: maps the raw 2-bit request op onto op_e (11 folds into compare)
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // The reserved code 11 is executed exactly like a compare.
    function automatic op_e decode_op(input logic [1:0] i_op);
        case (i_op)
            2'b00:   decode_op = OP_ADD;
            2'b01:   decode_op = OP_SUB;
            default: decode_op = OP_CMP;
        endcase
    endfunction

endpackage : alu_seq_pkg

// File: rtl/alu_nibble_cin.sv
// -----------------------------------------------------------------------------
// alu_nibble_cin
// 4-bit adder slice with optional b-invert and explicit carry-in/carry-out.
// Computes a + (b ^ {4{inv}}) + cin, so subtraction is a + ~b + 1 with cin=1.
// Configuration macro: ALU4B_SEQ_OVF_EN adds o_cmsb (carry into bit 3) for
// signed-overflow detection by the caller.
// Ports:
//   i_a, i_b  in  4  operand nibbles
//   i_inv     in  1  invert b before the add
//   i_cin     in  1  carry into bit 0
//   o_sum     out 4  sum nibble
//   o_cout    out 1  carry out of bit 3
//   o_cmsb    out 1  carry into bit 3 (ALU4B_SEQ_OVF_EN only)
// -----------------------------------------------------------------------------
module alu_nibble_cin
    import alu_seq_pkg::*;
(
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_inv,
    input  logic              i_cin,
    output logic [NIBBLE-1:0] o_sum,
    output logic              o_cout
`ifdef ALU4B_SEQ_OVF_EN
    ,
    output logic              o_cmsb
`endif
);

    logic [NIBBLE-1:0] w_b;
    logic [NIBBLE:0]   w_sum_ext;

    assign w_b       = i_b ^ {NIBBLE{i_inv}};
    assign w_sum_ext = {1'b0, i_a} + {1'b0, w_b} + {{NIBBLE{1'b0}}, i_cin};
    assign o_sum     = w_sum_ext[NIBBLE-1:0];
    assign o_cout    = w_sum_ext[NIBBLE];

`ifdef ALU4B_SEQ_OVF_EN
    // The carry into the MSB is recovered from the MSB's own sum equation:
    // s3 = a3 ^ b3 ^ c3  =>  c3 = a3 ^ b3 ^ s3.
    assign o_cmsb = i_a[NIBBLE-1] ^ w_b[NIBBLE-1] ^ w_sum_ext[NIBBLE-1];
`endif

endmodule : alu_nibble_cin

// File: rtl/alu4b_secuenciador.sv
// -----------------------------------------------------------------------------
// alu4b_secuenciador
// Round-robin shares one 4-bit add/sub slice between two requesters and runs
// WIDTH-bit add, subtract and compare nibble-serially (LSB first), finishing
// WIDTH/4 cycles after the operands are captured.
// Configuration macro: ALU4B_SEQ_OVF_EN adds output ovf (signed overflow of
// the final nibble, 0 for compare).
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   req[1:0]          request per requester, held until its gnt bit
//   op0/op1           operation per requester (00 add, 01 sub, 10/11 compare)
//   a0/a1, b0/b1      unsigned operands per requester
//   gnt[1:0]          one-hot grant pulse; operands captured in this cycle
//   busy              high from the cycle after gnt through the done cycle
//   done, done_id     one-cycle completion pulse and the requester it serves
//   result            sum or difference (0 for compare)
//   carry             add: carry-out; sub/compare: borrow
//   gt, lt, eq        unsigned compare flags (all 0 for add)
//   ovf               ALU4B_SEQ_OVF_EN only
// -----------------------------------------------------------------------------
module alu4b_secuenciador
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             gt,
    output logic             lt,
    output logic             eq
`ifdef ALU4B_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Controller and datapath registers
    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_cy;
    logic             r_zero;     // every difference nibble so far was zero
    logic             r_id;       // requester currently being served
    logic             r_prio;     // requester favoured on a simultaneous request
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
`ifdef ALU4B_SEQ_OVF_EN
    logic             r_ovf;
`endif

    // Arbitration and slice wires
    logic [1:0]        w_gnt;
    logic              w_gid;
    logic              w_inv;
    logic              w_cin;
    logic [NIBBLE-1:0] w_sum;
    logic              w_cout;
    logic              w_last;
    logic              w_zero_all;
`ifdef ALU4B_SEQ_OVF_EN
    logic              w_cmsb;
`endif

    // Grant is combinational so that operands are captured at the end of the
    // very cycle the grant is shown. It is masked by rst_n so every output
    // reads 0 while reset is held.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n && (r_state == S_IDLE)) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_gid = w_gnt[1];

    // Subtract and compare run a + ~b + 1: the +1 enters on nibble 0 only,
    // later nibbles take the registered carry.
    assign w_inv = (r_op != OP_ADD);
    assign w_cin = (r_idx == '0) ? w_inv : r_cy;

    alu_nibble_cin u_nibble (
        .i_a    (r_a[NIBBLE-1:0]),
        .i_b    (r_b[NIBBLE-1:0]),
        .i_inv  (w_inv),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
`ifdef ALU4B_SEQ_OVF_EN
        ,
        .o_cmsb (w_cmsb)
`endif
    );

    assign w_last     = (r_idx == LAST_IDX);
    assign w_zero_all = r_zero && (w_sum == '0);

    // NOTE: reset is sampled on the clock edge only; all state, including the
    // operand and result registers, is cleared so an aborted run leaves
    // nothing behind.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_cy      <= 1'b0;
            r_zero    <= 1'b0;
            r_id      <= 1'b0;
            r_prio    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
`ifdef ALU4B_SEQ_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_op    <= decode_op(w_gid ? op1 : op0);
                        r_a     <= w_gid ? a1 : a0;
                        r_b     <= w_gid ? b1 : b0;
                        r_id    <= w_gid;
                        r_prio  <= ~w_gid;
                        r_idx   <= '0;
                        r_cy    <= 1'b0;
                        r_zero  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Operands shift right so the slice always sees nibble 0;
                    // result nibbles enter from the top, LSB ending at bit 0.
                    r_a      <= {{NIBBLE{1'b0}}, r_a[WIDTH-1:NIBBLE]};
                    r_b      <= {{NIBBLE{1'b0}}, r_b[WIDTH-1:NIBBLE]};
                    r_result <= {w_sum, r_result[WIDTH-1:NIBBLE]};
                    r_cy     <= w_cout;
                    r_zero   <= w_zero_all;
                    r_idx    <= r_idx + 1'b1;

                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        if (r_op == OP_CMP) begin
                            r_result <= '0;
                        end
                        if (r_op == OP_ADD) begin
                            r_carry <= w_cout;
                            r_gt    <= 1'b0;
                            r_lt    <= 1'b0;
                            r_eq    <= 1'b0;
                        end else begin
                            // Final carry 0 from a + ~b + 1 means a borrow.
                            r_carry <= ~w_cout;
                            r_lt    <= ~w_cout;
                            r_eq    <= w_zero_all;
                            r_gt    <= w_cout & ~w_zero_all;
                        end
`ifdef ALU4B_SEQ_OVF_EN
                        r_ovf <= (r_op != OP_CMP) & (w_cmsb ^ w_cout);
`endif
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = w_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign result  = r_result;
    assign carry   = r_carry;
    assign gt      = r_gt;
    assign lt      = r_lt;
    assign eq      = r_eq;
`ifdef ALU4B_SEQ_OVF_EN
    assign ovf     = r_ovf;
`endif

endmodule : alu4b_secuenciador

// File: tb/tb_alu4b_secuenciador.sv
// -----------------------------------------------------------------------------
// tb_alu4b_secuenciador
// Directed bench for alu4b_secuenciador (WIDTH=16). Expected values are hand
// computed. With ALU4B_SEQ_OVF_EN defined the ovf output is checked as well.
// -----------------------------------------------------------------------------
module tb_alu4b_secuenciador;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [1:0]       op0 = 2'b00;
    logic [1:0]       op1 = 2'b00;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             gt;
    logic             lt;
    logic             eq;
`ifdef ALU4B_SEQ_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    alu4b_secuenciador #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op0     (op0),
        .op1     (op1),
        .a0      (a0),
        .a1      (a1),
        .b0      (b0),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result),
        .carry   (carry),
        .gt      (gt),
        .lt      (lt),
        .eq      (eq)
`ifdef ALU4B_SEQ_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int who, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (who == 0) begin
            op0 = op; a0 = a; b0 = b; req[0] = 1'b1;
        end else begin
            op1 = op; a1 = a; b1 = b; req[1] = 1'b1;
        end
    endtask

    // Returns the first non-zero gnt seen at a falling edge, or 0 on timeout.
    task automatic wait_gnt(output logic [1:0] g);
        int k;
        k = 0;
        @(negedge clk);
        while (gnt == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        g = gnt;
    endtask

    // Counts falling edges after the grant cycle until done (bounded).
    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && cyc < 20);
    endtask

    task automatic check_outputs(input string tag, input int who,
                                 input logic [WIDTH-1:0] er, input logic ec,
                                 input logic egt, input logic elt, input logic eeq,
                                 input logic eovf);
        check({tag, ".done_id"}, {31'b0, done_id}, who);
        check({tag, ".result"}, {16'b0, result}, {16'b0, er});
        check({tag, ".carry"}, {31'b0, carry}, {31'b0, ec});
        check({tag, ".gt_lt_eq"}, {29'b0, gt, lt, eq}, {29'b0, egt, elt, eeq});
`ifdef ALU4B_SEQ_OVF_EN
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eovf});
`else
        if (eovf) begin end
`endif
    endtask

    // One complete transaction from a single requester. Operands are scrambled
    // right after the grant to confirm they were captured.
    task automatic run_op(input string tag, input int who, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] er, input logic ec,
                          input logic egt, input logic elt, input logic eeq,
                          input logic eovf);
        logic [1:0] g;
        int         cyc;
        logic       bok;
        @(posedge clk); #1;
        drive(who, op, a, b);
        wait_gnt(g);
        check({tag, ".gnt"}, {30'b0, g}, (who == 0) ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        req[who] = 1'b0;
        drive(who, ~op, ~a, ~b);
        req[who] = 1'b0;
        wait_done(cyc, bok);
        check({tag, ".latency"}, cyc, 5);
        check({tag, ".busy"}, {31'b0, bok}, 32'h1);
        check_outputs(tag, who, er, ec, egt, elt, eeq, eovf);
        @(negedge clk);
        check({tag, ".done_pulse"}, {30'b0, done, busy}, 32'h0);
    endtask

    initial begin
        logic [1:0] g;
        int         cyc;
        logic       bok;
        logic       saw_done;

        // Reset state, with both requests high to confirm gnt stays quiet.
        req = 2'b11;
        repeat (2) @(negedge clk);
        check("reset.gnt", {30'b0, gnt}, 32'h0);
        check("reset.ctl", {29'b0, busy, done, done_id}, 32'h0);
        check("reset.result", {16'b0, result}, 32'h0);
        check("reset.flags", {28'b0, carry, gt, lt, eq}, 32'h0);
`ifdef ALU4B_SEQ_OVF_EN
        check("reset.ovf", {31'b0, ovf}, 32'h0);
`endif
        @(posedge clk); #1;
        req = 2'b00;
        rst_n = 1'b1;

        // Round-robin with both requests held: 0,1,0,1.
        @(posedge clk); #1;
        drive(0, 2'b00, 16'h0001, 16'h0002);
        drive(1, 2'b01, 16'h0010, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            check($sformatf("rr%0d.gnt", i), {30'b0, g}, (i % 2 == 0) ? 32'h1 : 32'h2);
            wait_done(cyc, bok);
            if (i == 3) begin
                @(posedge clk); #1;
                req = 2'b00;
                @(negedge clk);
            end
            check($sformatf("rr%0d.latency", i), cyc, 5);
            if (i % 2 == 0)
                check_outputs($sformatf("rr%0d", i), 0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                check_outputs($sformatf("rr%0d", i), 1, 16'h000F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Directed arithmetic vectors.
        run_op("add_wrap", 0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg",  1, 2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub_pos",  0, 2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("cmp_eq",   1, 2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("cmp_rsv",  0, 2'b11, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("cmp_gt",   1, 2'b10, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle aborts the operation.
        @(posedge clk); #1;
        drive(0, 2'b01, 16'h0009, 16'h0004);
        wait_gnt(g);
        check("abort.gnt", {30'b0, g}, 32'h1);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.busy_done", {30'b0, busy, done}, 32'h0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort.no_done", {31'b0, saw_done}, 32'h0);
        run_op("after_abort", 1, 2'b01, 16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ALU4B_SEQ_OVF_EN
        run_op("ovf_add", 0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("ovf_sub", 1, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("ovf_none", 0, 2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("ovf_cmp", 1, 2'b10, 16'h7FFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule : tb_alu4b_secuenciador
